// File: rtl/led_pkg.sv
// Shared definitions for the LED frame scheduler and the pin-mapping wrapper.
package led_pkg;

    localparam int unsigned LED_W = 12;

    // Bit positions inside the 12-bit LED bus, MSB = LED1 red
    localparam int unsigned LED1_R = 11;
    localparam int unsigned LED1_G = 10;
    localparam int unsigned LED1_B = 9;
    localparam int unsigned LED2_R = 8;
    localparam int unsigned LED2_G = 7;
    localparam int unsigned LED2_B = 6;
    localparam int unsigned LED3_R = 5;
    localparam int unsigned LED3_G = 4;
    localparam int unsigned LED3_B = 3;
    localparam int unsigned LED4_R = 2;
    localparam int unsigned LED4_G = 1;
    localparam int unsigned LED4_B = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BG     = 2'd1,
        EV_ON  = 2'd2,
        EV_OFF = 2'd3
    } led_state_e;

endpackage

// File: rtl/led_hold_timer.sv
// Phase down-counter: load restarts a HOLD_CYCLES-long phase, expired marks its last cycle.
module led_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    localparam int unsigned TIMER_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(HOLD_CYCLES - 1);

    logic [TIMER_W-1:0] count;
    logic [TIMER_W-1:0] count_nxt;

    // Reload on state entry, otherwise count down and park at zero
    always_comb begin
        count_nxt = count;
        if (load) begin
            count_nxt = RELOAD;
        end else if (count != '0) begin
            count_nxt = count - TIMER_W'(1);
        end
    end

    // Counter register; expired is registered alongside so it tracks count==0 exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            expired <= 1'b1;
        end else begin
            count   <= count_nxt;
            expired <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/led_frame_sched.sv
// Shares the LED bus between a priority blinking event source (A) and a steady background source (B).
module led_frame_sched
    import led_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 25_000_000,
    parameter int unsigned BLINK_COUNT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic [LED_W-1:0]  pat_a,
    output logic              ack_a,
    output logic              done_a,
    input  logic              req_b,
    input  logic [LED_W-1:0]  pat_b,
    output logic              ack_b,
    output logic              busy,
    output logic [LED_W-1:0]  led
);

    localparam int unsigned BLINK_W = $clog2(BLINK_COUNT + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_COUNT - 1);

    led_state_e          state, state_nxt;
    logic [LED_W-1:0]    frame_a, frame_a_nxt;
    logic [LED_W-1:0]    frame_b, frame_b_nxt;
    logic [BLINK_W-1:0]  blink, blink_nxt;
    logic [LED_W-1:0]    led_nxt;
    logic                ack_a_nxt, ack_b_nxt, done_a_nxt, busy_nxt;
    logic                load, expired, arbitrate;

    led_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .expired (expired)
    );

    // Next-state, arbitration and next-output logic
    always_comb begin
        state_nxt   = state;
        frame_a_nxt = frame_a;
        frame_b_nxt = frame_b;
        blink_nxt   = blink;
        ack_a_nxt   = 1'b0;
        ack_b_nxt   = 1'b0;
        done_a_nxt  = 1'b0;
        load        = 1'b0;
        arbitrate   = 1'b0;
        led_nxt     = '0;
        busy_nxt    = 1'b0;

        case (state)
            IDLE: arbitrate = 1'b1;
            // An event preempts the background frame immediately
            BG: arbitrate = req_a || expired;
            EV_ON: begin
                if (expired) begin
                    state_nxt = EV_OFF;
                    load      = 1'b1;
                end
            end
            EV_OFF: begin
                if (expired) begin
                    if (blink < BLINK_LAST) begin
                        blink_nxt = blink + BLINK_W'(1);
                        state_nxt = EV_ON;
                        load      = 1'b1;
                    end else begin
                        done_a_nxt = 1'b1;
                        arbitrate  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (arbitrate) begin
            if (req_a) begin
                state_nxt   = EV_ON;
                frame_a_nxt = pat_a;
                blink_nxt   = '0;
                ack_a_nxt   = 1'b1;
                load        = 1'b1;
            end else if (req_b) begin
                state_nxt   = BG;
                frame_b_nxt = pat_b;
                ack_b_nxt   = 1'b1;
                load        = 1'b1;
            end else begin
                state_nxt = IDLE;
            end
        end

        case (state_nxt)
            BG:      led_nxt = frame_b_nxt;
            EV_ON:   led_nxt = frame_a_nxt;
            default: led_nxt = '0;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State, latched frames and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            frame_a <= '0;
            frame_b <= '0;
            blink   <= '0;
            ack_a   <= 1'b0;
            ack_b   <= 1'b0;
            done_a  <= 1'b0;
            busy    <= 1'b0;
            led     <= '0;
        end else begin
            state   <= state_nxt;
            frame_a <= frame_a_nxt;
            frame_b <= frame_b_nxt;
            blink   <= blink_nxt;
            ack_a   <= ack_a_nxt;
            ack_b   <= ack_b_nxt;
            done_a  <= done_a_nxt;
            busy    <= busy_nxt;
            led     <= led_nxt;
        end
    end

endmodule

// File: tb/tb_led_frame_sched.sv
// Bench for led_frame_sched: directed scenarios plus random traffic against a frame-queue model.
module tb_led_frame_sched;

    localparam int unsigned H = 4;
    localparam int unsigned B = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, req_b;
    logic [11:0] pat_a, pat_b;
    logic        ack_a, ack_b, done_a, busy;
    logic [11:0] led;

    int checks   = 0;
    int failures = 0;
    bit b_hold   = 1'b0;

    // Reference model: queue of LED values still to be shown by the current activity
    logic [11:0] q[$];
    int          kind;      // 0 none, 1 background frame, 2 event
    logic [11:0] m_led;
    logic        m_ack_a, m_ack_b, m_done, m_busy;

    led_frame_sched #(
        .HOLD_CYCLES (H),
        .BLINK_COUNT (B)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_a  (req_a),
        .pat_a  (pat_a),
        .ack_a  (ack_a),
        .done_a (done_a),
        .req_b  (req_b),
        .pat_b  (pat_b),
        .ack_b  (ack_b),
        .busy   (busy),
        .led    (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge
    task automatic model_step();
        bit dec;
        m_ack_a = 1'b0;
        m_ack_b = 1'b0;
        m_done  = 1'b0;
        if (rst) begin
            q.delete();
            kind  = 0;
            m_led = '0;
        end else begin
            dec = (kind == 0) || (q.size() == 0) || (kind == 1 && req_a);
            if (kind == 2 && q.size() == 0) m_done = 1'b1;
            if (dec) begin
                q.delete();
                if (req_a) begin
                    kind = 2;
                    for (int b = 0; b < int'(B); b++) begin
                        for (int h = 0; h < int'(H); h++) q.push_back(pat_a);
                        for (int h = 0; h < int'(H); h++) q.push_back(12'h000);
                    end
                    m_ack_a = 1'b1;
                end else if (req_b) begin
                    kind = 1;
                    for (int h = 0; h < int'(H); h++) q.push_back(pat_b);
                    m_ack_b = 1'b1;
                end else begin
                    kind = 0;
                end
            end
            m_led = (kind == 0) ? 12'h000 : q.pop_front();
        end
        m_busy = (kind != 0);
    endtask

    // One clock: update model, compare every output, then behave like the requesters
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("led",    16'(led),    16'(m_led));
        chk("ack_a",  16'(ack_a),  16'(m_ack_a));
        chk("ack_b",  16'(ack_b),  16'(m_ack_b));
        chk("done_a", 16'(done_a), 16'(m_done));
        chk("busy",   16'(busy),   16'(m_busy));
        if (ack_a) req_a = 1'b0;
        if (ack_b && !b_hold) req_b = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!busy) begin
                got = 1'b1;
                break;
            end
        end
        chk(tag, 16'(got), 16'd1);
    endtask

    task automatic wait_ack_a(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ack_a) begin
                got = 1'b1;
                break;
            end
        end
        chk(tag, 16'(got), 16'd1);
    endtask

    initial begin
        int n;
        int dones;
        bit got;
        kind  = 0;
        rst   = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        pat_a = '0;
        pat_b = '0;

        // Reset, then idle
        repeat (3) tick();
        chk("rst_led", 16'(led), 16'h0000);
        chk("rst_busy", 16'(busy), 16'd0);
        rst = 1'b0;
        repeat (20) tick();

        // Background only, pattern changing underneath
        b_hold = 1'b1;
        req_b  = 1'b1;
        pat_b  = 12'hA5C;
        tick();
        chk("bg_first_ack", 16'(ack_b), 16'd1);
        chk("bg_first_led", 16'(led), 16'h0A5C);
        for (int i = 0; i < 16; i++) begin
            pat_b = 12'($urandom);
            tick();
        end
        b_hold = 1'b0;
        req_b  = 1'b0;
        wait_idle("bg_to_idle_timeout");

        // Event from idle
        pat_a = 12'hFFF;
        req_a = 1'b1;
        wait_ack_a("ev_ack_timeout");
        chk("ev_first_led", 16'(led), 16'h0FFF);
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (done_a) begin
                got = 1'b1;
                break;
            end
        end
        chk("ev_done_latency", 16'(n), 16'(2 * B * H));
        chk("ev_done_seen", 16'(got), 16'd1);
        chk("ev_then_idle", 16'(busy), 16'd0);

        // Preemption of a background frame at timer=2
        b_hold = 1'b1;
        req_b  = 1'b1;
        pat_b  = 12'h123;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack_b) begin
                got = 1'b1;
                break;
            end
        end
        chk("pre_bg_ack_timeout", 16'(got), 16'd1);
        tick();
        pat_a = 12'h800;
        req_a = 1'b1;
        tick();
        chk("pre_ack_a", 16'(ack_a), 16'd1);
        chk("pre_led", 16'(led), 16'h0800);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_a) begin
                got = 1'b1;
                break;
            end
        end
        chk("pre_done_timeout", 16'(got), 16'd1);
        chk("pre_resume_ack_b", 16'(ack_b), 16'd1);
        chk("pre_resume_led", 16'(led), 16'h0123);
        b_hold = 1'b0;
        req_b  = 1'b0;
        wait_idle("pre_idle_timeout");

        // Second event request raised during EV_OFF is held off until done
        pat_a = 12'h3C3;
        req_a = 1'b1;
        wait_ack_a("ign_first_ack_timeout");
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (led == 12'h000 && busy) begin
                got = 1'b1;
                break;
            end
        end
        chk("ign_ev_off_timeout", 16'(got), 16'd1);
        pat_a = 12'h00F;
        req_a = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_a) begin
                got = 1'b1;
                break;
            end
            chk("ign_no_ack", 16'(ack_a), 16'd0);
        end
        chk("ign_done_timeout", 16'(got), 16'd1);
        chk("ign_ack_with_done", 16'(ack_a), 16'd1);
        chk("ign_new_led", 16'(led), 16'h000F);
        repeat (2 * B * H) tick();
        chk("ign_second_done", 16'(done_a), 16'd1);
        wait_idle("ign_idle_timeout");

        // Reset during EV_ON drops the event silently
        pat_a = 12'h5A5;
        req_a = 1'b1;
        wait_ack_a("mid_ack_timeout");
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_led", 16'(led), 16'h0000);
        chk("mid_rst_busy", 16'(busy), 16'd0);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done_a) dones++;
        end
        chk("mid_no_done", 16'(dones), 16'd0);

        // Random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if (!req_a) begin
                pat_a = 12'($urandom);
                if ($urandom_range(0, 24) == 0) req_a = 1'b1;
            end
            if (!req_b && $urandom_range(0, 5) == 0) req_b = 1'b1;
            pat_b = 12'($urandom);
            rst   = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
